// File: rtl/peach_pkg.sv
// rtl/peach_pkg.sv - shared peach32 constants, LSU state type and request legality check
package peach_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_t;

    // Illegal funct3 for the direction, or a half/word access that is not naturally aligned.
    function automatic logic lsu_req_err(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic legal;
        logic misaligned;
        legal      = we ? (f3 == F3_B || f3 == F3_H || f3 == F3_W)
                        : (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
        misaligned = (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
        return !legal || misaligned;
    endfunction

endpackage

// File: rtl/peach_lsu_if.sv
// rtl/peach_lsu_if.sv - core request/response and RAM port bundle for the peach32 LSU
interface peach_lsu_if #(parameter int ADDR_W = 12);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              mem_en;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, mem_ack,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, mem_ack,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/peach_load_extend.sv
// rtl/peach_load_extend.sv - RV32I load lane select and sign/zero extension
module peach_load_extend
    import peach_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] ext
);

    logic [31:0] lane;

    always_comb begin
        lane = rdata >> {addr, 3'b000};
        case (funct3)
            F3_B:    ext = {{24{lane[7]}}, lane[7:0]};
            F3_H:    ext = {{16{lane[15]}}, lane[15:0]};
            F3_W:    ext = lane;
            F3_BU:   ext = {24'h0, lane[7:0]};
            F3_HU:   ext = {16'h0, lane[15:0]};
            default: ext = 32'h0;
        endcase
    end

endmodule

// File: rtl/peach_lsu.sv
// rtl/peach_lsu.sv - peach32 load/store unit; optional LED MMIO register under PEACH_LSU_MMIO_EN
module peach_lsu
    import peach_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
    input  logic             clk,
    input  logic             reset,
    peach_lsu_if.slave       bus,
    output logic [7:0]       led_out
);

    lsu_state_t        state, state_nx;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic              accept;
    logic              req_err;
    logic              is_mmio;
    logic [3:0]        be_c;
    logic [31:0]       wdata_c;
    logic [31:0]       ext_in;
    logic [1:0]        ext_off;
    logic [2:0]        ext_f3;
    logic [31:0]       ext_out;

    assign accept  = bus.req_valid && (state == IDLE);
    assign req_err = lsu_req_err(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);

`ifdef PEACH_LSU_MMIO_EN
    assign is_mmio = (bus.req_addr[31:2] == MMIO_BASE[31:2]);
`else
    assign is_mmio = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = &{1'b0, bus.req_addr[31:ADDR_W+2], MMIO_BASE};

    always_comb begin
        be_c    = 4'b0000;
        wdata_c = bus.req_wdata;
        case (bus.req_funct3[1:0])
            2'b00: begin
                be_c    = 4'b0001 << bus.req_addr[1:0];
                wdata_c = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                be_c    = 4'b0011 << bus.req_addr[1:0];
                wdata_c = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = bus.req_wdata;
            end
        endcase
    end

    // One extender serves both paths: MMIO loads resolve at accept (lane 0 of the LED byte),
    // RAM loads resolve on ack with the latched offset and funct3.
    always_comb begin
        if (state == IDLE) begin
            ext_in  = {24'h0, led_out};
            ext_off = 2'b00;
            ext_f3  = bus.req_funct3;
        end else begin
            ext_in  = bus.mem_rdata;
            ext_off = off_q;
            ext_f3  = f3_q;
        end
    end

    peach_load_extend u_load_extend (
        .rdata  (ext_in),
        .addr   (ext_off),
        .funct3 (ext_f3),
        .ext    (ext_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = (req_err || is_mmio) ? RESP : ACCESS;
            ACCESS:  if (bus.mem_ack) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state == IDLE);
        bus.rsp_valid = (state == RESP);
        bus.mem_en    = (state == ACCESS);
        bus.mem_we    = (state == ACCESS) && we_q;
        bus.rsp_rdata = rdata_q;
        bus.rsp_err   = err_q;
        bus.mem_be    = be_q;
        bus.mem_addr  = waddr_q;
        bus.mem_wdata = wdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            off_q   <= 2'b00;
            waddr_q <= '0;
            be_q    <= 4'b0000;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= bus.req_we;
                f3_q    <= bus.req_funct3;
                off_q   <= bus.req_addr[1:0];
                waddr_q <= bus.req_addr[ADDR_W+1:2];
                be_q    <= be_c;
                wdata_q <= wdata_c;
                err_q   <= req_err;
                rdata_q <= (is_mmio && !req_err && !bus.req_we) ? ext_out : 32'h0;
            end else if (state == ACCESS && bus.mem_ack) begin
                rdata_q <= we_q ? 32'h0 : ext_out;
            end
        end
    end

`ifdef PEACH_LSU_MMIO_EN
    logic [7:0] led_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            led_q <= 8'h00;
        else if (accept && is_mmio && !req_err && bus.req_we)
            led_q <= bus.req_wdata[7:0];
    end
    assign led_out = led_q;
`else
    assign led_out = 8'h00;
`endif

endmodule

// File: tb/tb_peach_lsu.sv
// tb/tb_peach_lsu.sv - directed self-checking bench for peach_lsu
module tb_peach_lsu;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] led;

    peach_lsu_if #(.ADDR_W(12)) bus ();

    peach_lsu #(.ADDR_W(12), .MMIO_BASE(32'hFFFF_FF00)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .led_out (led)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          en_cnt;
    int          lat;
    logic [31:0] c_rd;
    logic        c_err;
    logic [3:0]  c_be;
    logic [11:0] c_addr;
    logic [31:0] c_wdata;
    logic        c_we;
    int          rsp_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request, ack after wait_n extra ACCESS cycles, record what the RAM port and response showed.
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata, input int wait_n);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.mem_rdata  = rdata;
        check("req_ready_idle", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        en_cnt = 0; lat = 0; c_rd = 'x; c_err = 'x;
        c_be = '0; c_addr = '0; c_wdata = '0; c_we = 1'b0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            if (bus.mem_en) begin
                en_cnt++;
                if (en_cnt == 1) begin
                    c_be = bus.mem_be; c_addr = bus.mem_addr;
                    c_wdata = bus.mem_wdata; c_we = bus.mem_we;
                end
                bus.mem_ack = (en_cnt == wait_n + 1);
            end else begin
                bus.mem_ack = 1'b0;
            end
            if (bus.rsp_valid) begin
                lat = k; c_rd = bus.rsp_rdata; c_err = bus.rsp_err;
            end
        end
        bus.mem_ack = 1'b0;
        @(negedge clk);
        check("rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.mem_rdata = 32'h0; bus.mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_mem_en",    32'(bus.mem_en),    32'd0);
        check("rst_mem_be",    32'(bus.mem_be),    32'd0);
        check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
        check("rst_mem_wdata", bus.mem_wdata,      32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata,      32'd0);
        check("rst_led",       32'(led),           32'd0);
        reset = 1'b0;

        run_op(1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 0);
        check("sw_addr",  32'(c_addr), 32'h4);
        check("sw_be",    32'(c_be),   32'hF);
        check("sw_wdata", c_wdata,     32'hDEAD_BEEF);
        check("sw_we",    32'(c_we),   32'd1);
        check("sw_lat",   32'(lat),    32'd2);
        check("sw_err",   32'(c_err),  32'd0);

        run_op(1'b0, 3'd0, 32'h0000_0013, 32'h0, 32'h80FF_1234, 0);
        check("lb_be",  32'(c_be), 32'h8);
        check("lb_we",  32'(c_we), 32'd0);
        check("lb_rd",  c_rd,      32'hFFFF_FF80);
        run_op(1'b0, 3'd4, 32'h0000_0013, 32'h0, 32'h80FF_1234, 0);
        check("lbu_rd", c_rd,      32'h0000_0080);

        run_op(1'b0, 3'd1, 32'h0000_0012, 32'h0, 32'h8001_0000, 3);
        check("lh_be",  32'(c_be),   32'hC);
        check("lh_en",  32'(en_cnt), 32'd4);
        check("lh_rd",  c_rd,        32'hFFFF_8001);
        check("lh_lat", 32'(lat),    32'd5);

        run_op(1'b0, 3'd5, 32'h0000_0002, 32'h0, 32'h8001_7777, 1);
        check("lhu_rd", c_rd, 32'h0000_8001);

        run_op(1'b0, 3'd2, 32'h0000_0002, 32'h0, 32'h1234_5678, 0);
        check("lw_mis_err", 32'(c_err),  32'd1);
        check("lw_mis_rd",  c_rd,        32'd0);
        check("lw_mis_en",  32'(en_cnt), 32'd0);
        check("lw_mis_lat", 32'(lat),    32'd1);
        run_op(1'b0, 3'd3, 32'h0000_0000, 32'h0, 32'h1234_5678, 0);
        check("ld_f3_err",  32'(c_err),  32'd1);
        check("ld_f3_rd",   c_rd,        32'd0);
        check("ld_f3_en",   32'(en_cnt), 32'd0);
        run_op(1'b1, 3'd4, 32'h0000_0000, 32'h1, 32'h0, 0);
        check("st_f3_err",  32'(c_err),  32'd1);
        check("st_f3_en",   32'(en_cnt), 32'd0);

        run_op(1'b1, 3'd0, 32'h0000_0021, 32'h0000_00AB, 32'h0, 0);
        check("sb_be",    32'(c_be),  32'h2);
        check("sb_addr",  32'(c_addr), 32'h8);
        check("sb_wdata", c_wdata,    32'hABAB_ABAB);
        check("sb_rd",    c_rd,       32'd0);
        run_op(1'b1, 3'd1, 32'h0000_0006, 32'h1234_CAFE, 32'h0, 2);
        check("sh_be",    32'(c_be),  32'hC);
        check("sh_wdata", c_wdata,    32'hCAFE_CAFE);
        check("sh_lat",   32'(lat),   32'd4);

        run_op(1'b0, 3'd2, 32'hFFFF_0040, 32'h0, 32'hCAFE_F00D, 0);
        check("alias_addr", 32'(c_addr), 32'h010);
        check("alias_rd",   c_rd,        32'hCAFE_F00D);

        @(negedge clk);
        bus.mem_ack = 1'b1;
        @(negedge clk);
        check("ack_idle_rsp",   32'(bus.rsp_valid), 32'd0);
        check("ack_idle_ready", 32'(bus.req_ready), 32'd1);
        bus.mem_ack = 1'b0;

`ifdef PEACH_LSU_MMIO_EN
        run_op(1'b1, 3'd2, 32'hFFFF_FF00, 32'h0000_005A, 32'h0, 0);
        check("mmio_sw_en",  32'(en_cnt), 32'd0);
        check("mmio_sw_lat", 32'(lat),    32'd1);
        check("mmio_led",    32'(led),    32'h5A);
        run_op(1'b0, 3'd4, 32'hFFFF_FF00, 32'h0, 32'hFFFF_FFFF, 0);
        check("mmio_lbu_rd", c_rd,        32'h0000_005A);
        check("mmio_lbu_en", 32'(en_cnt), 32'd0);
`else
        run_op(1'b1, 3'd2, 32'hFFFF_FF00, 32'h0000_005A, 32'h0, 0);
        check("nommio_en",   32'(en_cnt), 32'd1);
        check("nommio_addr", 32'(c_addr), 32'hFC0);
        check("nommio_led",  32'(led),    32'h00);
`endif

        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'd2;
        bus.req_addr = 32'h0000_0040; bus.mem_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("abort_pre_en", 32'(bus.mem_en), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("abort_en",    32'(bus.mem_en),    32'd0);
        check("abort_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        rsp_seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) rsp_seen++;
        end
        check("abort_no_rsp", 32'(rsp_seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
